regbank_wr8_x64: RTL and testbench



---
 rtl/regbank_wr8_x64_pkg.sv | 14 +
 rtl/regbank_wr8_x64_decoder3_to_8.sv | 17 +
 rtl/regbank_wr8_x64.sv | 105 ++++++++++
 tb/tb_regbank_wr8_x64.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regbank_wr8_x64_pkg.sv
// Shared constants and state encoding for the x64 eight-entry register bank
// and its companion read mux / register-file top level.
package regbank_wr8_x64_pkg;

  localparam int unsigned REGBANK_W     = 64;
  localparam int unsigned REGBANK_N     = 8;
  localparam int unsigned REGBANK_SEL_W = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } regbank_state_t;

endpackage

// File: rtl/regbank_wr8_x64_decoder3_to_8.sv
// One-hot write-enable decoder: turns the staged register index into the
// eight per-register write enables, all low when no commit is happening.
module decoder3_to_8
  import regbank_wr8_x64_pkg::*;
(
  input  logic [REGBANK_SEL_W-1:0] sel,
  input  logic                     en,
  output logic [REGBANK_N-1:0]     onehot
);

  // Decode sel into a single asserted enable, gated by en
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/regbank_wr8_x64.sv
// Eight 64-bit registers written one at a time through a valid/ready port.
// A one-entry staging register absorbs the producer write so that hold only
// stalls the commit into the bank; all contents are presented in parallel.
module regbank_wr8_x64
  import regbank_wr8_x64_pkg::*;
#(
  parameter int WIDTH = REGBANK_W,
  parameter int NREG  = REGBANK_N
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REGBANK_SEL_W-1:0] S,
  input  logic [WIDTH-1:0]         D,
  input  logic                     hold,
  input  logic                     clr,
  output logic [WIDTH-1:0]         Q0,
  output logic [WIDTH-1:0]         Q1,
  output logic [WIDTH-1:0]         Q2,
  output logic [WIDTH-1:0]         Q3,
  output logic [WIDTH-1:0]         Q4,
  output logic [WIDTH-1:0]         Q5,
  output logic [WIDTH-1:0]         Q6,
  output logic [WIDTH-1:0]         Q7,
  output logic [NREG-1:0]          VLD,
  output logic                     busy,
  output logic [15:0]              wr_cnt
);

  regbank_state_t           state;
  logic [REGBANK_SEL_W-1:0] stage_sel;
  logic [WIDTH-1:0]         stage_data;
  logic [WIDTH-1:0]         bank [NREG];
  logic [NREG-1:0]          vld;
  logic [15:0]              cnt;
  logic [NREG-1:0]          we;
  logic                     accept;
  logic                     commit;

  assign busy     = (state == ST_FULL);
  assign in_ready = !clr && (!busy || !hold);
  assign accept   = in_valid && in_ready;
  assign commit   = busy && !hold && !clr;

  decoder3_to_8 u_dec (
    .sel    (stage_sel),
    .en     (commit),
    .onehot (we)
  );

  // Staging register and EMPTY/FULL control; clr discards any staged write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      stage_sel  <= '0;
      stage_data <= '0;
    end else if (clr) begin
      state      <= ST_EMPTY;
      stage_sel  <= '0;
      stage_data <= '0;
    end else begin
      if (accept) begin
        stage_sel  <= S;
        stage_data <= D;
      end
      case (state)
        ST_EMPTY: if (accept) state <= ST_FULL;
        ST_FULL:  if (commit && !accept) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  // Register bank, written flags and commit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) bank[i] <= '0;
      vld <= '0;
      cnt <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < NREG; i++) bank[i] <= '0;
      vld <= '0;
      cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (we[i[REGBANK_SEL_W-1:0]]) bank[i] <= stage_data;
      end
      vld <= vld | we;
      if (commit) cnt <= cnt + 16'd1;
    end
  end

  assign Q0     = bank[0];
  assign Q1     = bank[1];
  assign Q2     = bank[2];
  assign Q3     = bank[3];
  assign Q4     = bank[4];
  assign Q5     = bank[5];
  assign Q6     = bank[6];
  assign Q7     = bank[7];
  assign VLD    = vld;
  assign wr_cnt = cnt;

endmodule

// File: tb/tb_regbank_wr8_x64.sv
// Directed self-checking bench for regbank_wr8_x64.
module tb_regbank_wr8_x64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  S;
  logic [63:0] D;
  logic        hold;
  logic        clr;
  logic [63:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
  logic [7:0]  VLD;
  logic        busy;
  logic [15:0] wr_cnt;

  logic [63:0] qv [8];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regbank_wr8_x64 #(.WIDTH(64), .NREG(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .S        (S),
    .D        (D),
    .hold     (hold),
    .clr      (clr),
    .Q0       (Q0),
    .Q1       (Q1),
    .Q2       (Q2),
    .Q3       (Q3),
    .Q4       (Q4),
    .Q5       (Q5),
    .Q6       (Q6),
    .Q7       (Q7),
    .VLD      (VLD),
    .busy     (busy),
    .wr_cnt   (wr_cnt)
  );

  always_comb begin
    qv[0] = Q0; qv[1] = Q1; qv[2] = Q2; qv[3] = Q3;
    qv[4] = Q4; qv[5] = Q5; qv[6] = Q6; qv[7] = Q7;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp;
    rst_n = 1'b0; in_valid = 1'b0; S = '0; D = '0; hold = 1'b0; clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-run: one committed write, one staged write stalled by hold
    in_valid = 1'b1; S = 3'd1; D = 64'h0000_0000_0000_00AB;
    tick();
    S = 3'd4; D = 64'h0000_0000_0000_00CD;
    tick();
    in_valid = 1'b0; hold = 1'b1;
    tick();
    check_eq("pre_rst_q1", Q1, 64'h0000_0000_0000_00AB);
    check_eq("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1; hold = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) check_eq($sformatf("rst_q%0d", i), qv[i], 64'd0);
    check_eq("rst_vld", 64'(VLD), 64'h00);
    check_eq("rst_cnt", 64'(wr_cnt), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ready", 64'(in_ready), 64'd1);
    tick();
    check_eq("rst_q4_lost", Q4, 64'd0);

    // Streaming writes: Qi appears one edge after its accept
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; S = 3'(i); D = 64'h1111_1111_1111_1111 * 64'(i + 1);
      #1;
      check_eq($sformatf("stream_ready%0d", i), 64'(in_ready), 64'd1);
      tick();
      check_eq($sformatf("stream_not_yet%0d", i), qv[i], 64'd0);
      if (i > 0) check_eq($sformatf("stream_q%0d", i - 1), qv[i - 1],
                          64'h1111_1111_1111_1111 * 64'(i));
    end
    in_valid = 1'b0;
    tick();
    check_eq("stream_q7", Q7, 64'h8888_8888_8888_8888);
    check_eq("stream_vld", 64'(VLD), 64'hFF);
    check_eq("stream_cnt", 64'(wr_cnt), 64'd8);
    check_eq("stream_busy", 64'(busy), 64'd0);

    // Hold stalls the commit; release commits and accepts a new write
    in_valid = 1'b1; S = 3'd3; D = 64'hDEAD_BEEF_0000_0001;
    tick();
    in_valid = 1'b0; hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq($sformatf("hold_ready%0d", c), 64'(in_ready), 64'd0);
      tick();
      check_eq($sformatf("hold_busy%0d", c), 64'(busy), 64'd1);
      check_eq($sformatf("hold_q3_%0d", c), Q3, 64'h4444_4444_4444_4444);
    end
    hold = 1'b0; in_valid = 1'b1; S = 3'd6; D = 64'h0123_4567_89AB_CDEF;
    #1;
    check_eq("release_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check_eq("release_q3", Q3, 64'hDEAD_BEEF_0000_0001);
    check_eq("release_busy", 64'(busy), 64'd1);
    tick();
    check_eq("release_q6", Q6, 64'h0123_4567_89AB_CDEF);
    check_eq("release_cnt", 64'(wr_cnt), 64'd10);
    check_eq("release_idle", 64'(busy), 64'd0);

    // Same index back-to-back: last write wins
    in_valid = 1'b1; S = 3'd5; D = 64'hA;
    tick();
    D = 64'hB;
    tick();
    in_valid = 1'b0;
    check_eq("same_first", Q5, 64'hA);
    tick();
    check_eq("same_last", Q5, 64'hB);
    check_eq("same_cnt", 64'(wr_cnt), 64'd12);
    check_eq("same_q4", Q4, 64'h5555_5555_5555_5555);
    check_eq("same_q6", Q6, 64'h0123_4567_89AB_CDEF);

    // clr wins over a pending commit and a concurrent offer
    in_valid = 1'b1; S = 3'd2; D = 64'h2222_FFFF_2222_FFFF; hold = 1'b1;
    tick();
    check_eq("clr_staged", 64'(busy), 64'd1);
    clr = 1'b1; hold = 1'b0; S = 3'd1; D = 64'h9999;
    #1;
    check_eq("clr_ready", 64'(in_ready), 64'd0);
    tick();
    clr = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) check_eq($sformatf("clr_q%0d", i), qv[i], 64'd0);
    check_eq("clr_vld", 64'(VLD), 64'h00);
    check_eq("clr_cnt", 64'(wr_cnt), 64'd0);
    check_eq("clr_busy", 64'(busy), 64'd0);
    tick(); tick();
    check_eq("clr_q2_never", Q2, 64'd0);
    check_eq("clr_cnt_still", 64'(wr_cnt), 64'd0);

    // Counter wrap: 65535 streamed commits, then one more
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      S = 3'(i % 8); D = 64'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check_eq("wrap_full", 64'(wr_cnt), 64'hFFFF);
    exp = 64'd65534;
    check_eq("wrap_q6_last", Q6, exp);
    check_eq("wrap_vld", 64'(VLD), 64'hFF);
    in_valid = 1'b1; S = 3'd0; D = 64'h1;
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("wrap_zero", 64'(wr_cnt), 64'h0000);
    check_eq("wrap_q0", Q0, 64'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
